wam_hit: RTL and testbench

WAM_HIT -- requirements
Module: wam_hit

---
 rtl/wam_hit_if.sv | 20 ++
 rtl/wam_hit.sv | 153 +++++++++++++++
 tb/tb_wam_hit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wam_hit_if.sv
// wam_hit_if -- game-side signal bundle for the whack-a-mole hit detector.
//   en      : game running; presses are ignored while low
//   restart : synchronous clear of score and misses
//   keys    : raw asynchronous push buttons, active-high, bit i = hole i
//   holes   : mole present per hole (same clock domain as the detector)
//   hit     : per-hole whack pending acknowledgement
//   score   : accepted hits, saturating at 9999
//   misses  : presses on empty holes, saturating at 255
interface wam_hit_if;
   logic        en;
   logic        restart;
   logic [7:0]  keys;
   logic [7:0]  holes;
   logic [7:0]  hit;
   logic [13:0] score;
   logic [7:0]  misses;

   modport master (output en, restart, keys, holes, input hit, score, misses);
   modport slave  (input en, restart, keys, holes, output hit, score, misses);
endinterface

// File: rtl/wam_hit.sv
// wam_hit -- debounces eight hole buttons, turns accepted whacks into
// per-hole hit strobes and keeps saturating score / miss counters.
//   clk   : single clock, all state on its rising edge
//   clr_n : asynchronous active-low clear of all state
//   bus   : wam_hit_if slave (en, restart, keys, holes -> hit, score, misses)
// Parameters:
//   DB_CYCLES   : cycles a synced key level must differ before it is accepted
//   HOLD_CYCLES : maximum cycles a hit strobe stays asserted
module wam_hit #(
   parameter int unsigned DB_CYCLES   = 16,
   parameter int unsigned HOLD_CYCLES = 1024
) (
   input  logic     clk,
   input  logic     clr_n,
   wam_hit_if.slave bus
);

   localparam int unsigned    HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [15:0]    DB_MAX    = 16'(DB_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES - 1);
   localparam logic [13:0]    SCORE_MAX = 14'd9999;
   localparam logic [7:0]     MISS_MAX  = 8'd255;

   typedef enum logic {IDLE, HOLD} state_e;

   logic [7:0]    sync1_q, sync2_q;
   logic [7:0]    lvl_q, lvl_d;
   logic [15:0]   dbc_q [8];
   logic [15:0]   dbc_d [8];
   logic [7:0]    press_q, press_d;
   state_e        st_q [8];
   state_e        st_d [8];
   logic [HW-1:0] hc_q [8];
   logic [HW-1:0] hc_d [8];
   logic [7:0]    accept, miss_ev;
   logic [3:0]    n_acc, n_miss;
   logic [14:0]   score_sum;
   logic [8:0]    miss_sum;
   logic [13:0]   score_q, score_d;
   logic [7:0]    miss_q, miss_d;

   // Synchronizer, debounce and press-event registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         press_q <= '0;
         for (int unsigned i = 0; i < 8; i++) dbc_q[i] <= '0;
      end else begin
         sync1_q <= bus.keys;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         press_q <= press_d;
         for (int unsigned i = 0; i < 8; i++) dbc_q[i] <= dbc_d[i];
      end
   end

   // Counter runs only while the synced level disagrees with the accepted
   // level; any agreement restarts the qualification window.
   always_comb begin
      lvl_d = lvl_q;
      for (int unsigned i = 0; i < 8; i++) begin
         dbc_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (dbc_q[i] == DB_MAX) lvl_d[i] = ~lvl_q[i];
            else                    dbc_d[i] = dbc_q[i] + 16'd1;
         end
      end
      // Only rising debounced edges are presses; releases are dropped here.
      press_d = lvl_d & ~lvl_q;
   end

   // Per-hole FSM state register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int unsigned i = 0; i < 8; i++) begin
            st_q[i] <= IDLE;
            hc_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 8; i++) begin
            st_q[i] <= st_d[i];
            hc_q[i] <= hc_d[i];
         end
      end
   end

   // Per-hole FSM next state; presses while in HOLD fall through unused.
   always_comb begin
      accept  = '0;
      miss_ev = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         st_d[i] = st_q[i];
         hc_d[i] = hc_q[i];
         case (st_q[i])
            IDLE: begin
               if (press_q[i] && bus.en) begin
                  if (bus.holes[i]) begin
                     st_d[i]   = HOLD;
                     hc_d[i]   = '0;
                     accept[i] = 1'b1;
                  end else begin
                     miss_ev[i] = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (!bus.en || !bus.holes[i] || (hc_q[i] == HOLD_MAX)) st_d[i] = IDLE;
               else                                                  hc_d[i] = hc_q[i] + HW'(1);
            end
            default: st_d[i] = IDLE;
         endcase
      end
   end

   // Score / miss accumulation with same-cycle saturation; restart wins.
   always_comb begin
      n_acc  = '0;
      n_miss = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n_acc  = n_acc  + {3'b000, accept[i]};
         n_miss = n_miss + {3'b000, miss_ev[i]};
      end
      score_sum = {1'b0, score_q} + {11'b0, n_acc};
      miss_sum  = {1'b0, miss_q}  + {5'b0, n_miss};
      score_d   = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
      miss_d    = miss_sum[8] ? MISS_MAX : miss_sum[7:0];
      if (bus.restart) begin
         score_d = '0;
         miss_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         score_q <= '0;
         miss_q  <= '0;
      end else begin
         score_q <= score_d;
         miss_q  <= miss_d;
      end
   end

   // hit is the HOLD state itself, so it drops with the async clear.
   always_comb begin
      for (int unsigned i = 0; i < 8; i++) bus.hit[i] = (st_q[i] == HOLD);
   end

   assign bus.score  = score_q;
   assign bus.misses = miss_q;

endmodule

// File: tb/tb_wam_hit.sv
// tb_wam_hit -- self-checking bench for wam_hit (DB_CYCLES=4, HOLD_CYCLES=8).
// Directed sequences and a vector table check absolute values; a behavioural
// model tracks the whole run and is compared against the outputs each cycle.
module tb_wam_hit;

   localparam int unsigned DB   = 4;
   localparam int unsigned HOLD = 8;

   logic clk   = 1'b0;
   logic clr_n = 1'b0;

   wam_hit_if bus();

   wam_hit #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural reference model ----------------
   // A key level is accepted once the synchronized key has disagreed with the
   // accepted level on each of the last DB edges, none of them at or before
   // the previous acceptance. Holes remember how many cycles of strobe remain.
   logic [7:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pend = '0;
   logic [7:0] m_hist[$];
   int         m_since[8];
   int         m_rem[8];
   int         m_score = 0;
   int         m_miss  = 0;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
      m_hist.delete();
      for (int i = 0; i < 8; i++) begin
         m_since[i] = DB;
         m_rem[i]   = 0;
      end
      m_score = 0;
      m_miss  = 0;
   endtask

   task automatic model_step();
      logic [7:0] cur, npend;
      int         nh, nm;
      bit         flip;
      cur  = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.keys;
      m_hist.push_back(cur);
      if (m_hist.size() > DB) m_hist.delete(0);
      nh = 0;
      nm = 0;
      for (int i = 0; i < 8; i++) begin
         if (m_rem[i] > 0) begin
            if (!bus.en || !bus.holes[i]) m_rem[i] = 0;
            else                          m_rem[i] = m_rem[i] - 1;
         end else if (m_pend[i] && bus.en) begin
            if (bus.holes[i]) begin
               nh++;
               m_rem[i] = HOLD;
            end else begin
               nm++;
            end
         end
      end
      npend = '0;
      for (int i = 0; i < 8; i++) begin
         if (m_since[i] < DB) m_since[i]++;
         flip = (m_hist.size() == DB) && (m_since[i] >= DB);
         foreach (m_hist[k]) if (m_hist[k][i] == m_lvl[i]) flip = 1'b0;
         if (flip) begin
            m_lvl[i]   = ~m_lvl[i];
            m_since[i] = 0;
            npend[i]   = m_lvl[i];
         end
      end
      m_pend = npend;
      if (bus.restart) begin
         m_score = 0;
         m_miss  = 0;
      end else begin
         m_score = (m_score + nh > 9999) ? 9999 : m_score + nh;
         m_miss  = (m_miss + nm > 255)   ? 255  : m_miss + nm;
      end
   endtask

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin : mchk
      logic [7:0] eh;
      for (int i = 0; i < 8; i++) eh[i] = (m_rem[i] > 0);
      chk("model_hit",    32'(bus.hit),    32'(eh));
      chk("model_score",  32'(bus.score),  32'(m_score));
      chk("model_misses", 32'(bus.misses), 32'(m_miss));
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] keys;
      logic [7:0] holes;
      logic       en;
      logic [7:0] hit;
      int         ds;
      int         dm;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [7:0] m;

      tbl[0] = '{8'hFF, 8'h0F, 1'b1, 8'h0F, 4, 4};
      tbl[1] = '{8'h81, 8'h80, 1'b1, 8'h80, 1, 1};
      tbl[2] = '{8'h3C, 8'hFF, 1'b1, 8'h3C, 4, 0};
      tbl[3] = '{8'h0F, 8'h0F, 1'b0, 8'h00, 0, 0};
      tbl[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 0, 8};

      bus.en = 1'b1; bus.restart = 1'b0; bus.keys = '0; bus.holes = '0;

      // reset state
      tick(3);
      chk("rst_hit",    32'(bus.hit),    32'h0);
      chk("rst_score",  32'(bus.score),  32'h0);
      chk("rst_misses", 32'(bus.misses), 32'h0);
      clr_n = 1'b1;
      tick(2);

      // debounce: 3-cycle glitch rejected, held press accepted after 2+DB+1
      bus.holes = 8'h04;
      bus.keys  = 8'h04; tick(3);
      bus.keys  = 8'h00; tick(10);
      chk("glitch_hit",   32'(bus.hit),   32'h0);
      chk("glitch_score", 32'(bus.score), 32'h0);
      bus.keys = 8'h04; tick(6);
      chk("db_early_hit", 32'(bus.hit), 32'h0);
      tick(1);
      chk("db_hit",   32'(bus.hit),   32'h04);
      chk("db_score", 32'(bus.score), 32'd1);
      tick(3);
      bus.keys = 8'h00; bus.holes = 8'h00; tick(1);
      chk("db_ack_hit", 32'(bus.hit), 32'h0);
      tick(8);

      // acknowledge, then a press on an empty hole
      bus.holes = 8'h20; bus.keys = 8'h20; tick(7);
      chk("ack_hit_on", 32'(bus.hit),   32'h20);
      chk("ack_score",  32'(bus.score), 32'd2);
      bus.holes = 8'h00; tick(1);
      chk("ack_hit_off", 32'(bus.hit), 32'h0);
      bus.keys = 8'h00; tick(8);
      bus.keys = 8'h20; tick(7);
      chk("miss_hit",    32'(bus.hit),    32'h0);
      chk("miss_misses", 32'(bus.misses), 32'd1);
      bus.keys = 8'h00; tick(8);

      // timeout after exactly HOLD cycles, then re-press
      bus.holes = 8'h01; bus.keys = 8'h01; tick(7);
      chk("to_first", 32'(bus.hit), 32'h01);
      tick(7);
      chk("to_last", 32'(bus.hit), 32'h01);
      tick(1);
      chk("to_drop",  32'(bus.hit),   32'h0);
      chk("to_score", 32'(bus.score), 32'd3);
      bus.keys = 8'h00; tick(8);
      bus.keys = 8'h01; tick(7);
      chk("to_repress_hit",   32'(bus.hit),   32'h01);
      chk("to_repress_score", 32'(bus.score), 32'd4);
      bus.holes = 8'h00; bus.keys = 8'h00; tick(8);

      // key held across en rising yields no press
      bus.restart = 1'b1; tick(1); bus.restart = 1'b0;
      chk("restart_score",  32'(bus.score),  32'h0);
      chk("restart_misses", 32'(bus.misses), 32'h0);
      bus.en = 1'b0; bus.holes = 8'h02; bus.keys = 8'h02; tick(12);
      chk("en_off_hit", 32'(bus.hit), 32'h0);
      bus.en = 1'b1; tick(10);
      chk("en_rise_hit",    32'(bus.hit),    32'h0);
      chk("en_rise_score",  32'(bus.score),  32'h0);
      chk("en_rise_misses", 32'(bus.misses), 32'h0);
      bus.keys = 8'h00; bus.holes = 8'h00; tick(8);

      // simultaneous-press table
      for (int v = 0; v < 5; v++) begin
         bus.en = tbl[v].en; bus.holes = tbl[v].holes;
         bus.restart = 1'b1; tick(1); bus.restart = 1'b0;
         bus.keys = tbl[v].keys; tick(7);
         chk($sformatf("tbl%0d_hit", v),    32'(bus.hit),    32'(tbl[v].hit));
         chk($sformatf("tbl%0d_score", v),  32'(bus.score),  32'(tbl[v].ds));
         chk($sformatf("tbl%0d_misses", v), 32'(bus.misses), 32'(tbl[v].dm));
         bus.keys = 8'h00; bus.holes = 8'h00; bus.en = 1'b1; tick(8);
      end

      // asynchronous clear mid-HOLD, key held through reset
      bus.holes = 8'h01; bus.keys = 8'h01; tick(7);
      chk("pre_rst_hit", 32'(bus.hit), 32'h01);
      #2 clr_n = 1'b0;
      #1;
      chk("async_hit",    32'(bus.hit),    32'h0);
      chk("async_score",  32'(bus.score),  32'h0);
      chk("async_misses", 32'(bus.misses), 32'h0);
      @(negedge clk);
      clr_n = 1'b1;
      tick(6);
      chk("post_rst_early", 32'(bus.hit), 32'h0);
      tick(1);
      chk("post_rst_hit",   32'(bus.hit),   32'h01);
      chk("post_rst_score", 32'(bus.score), 32'd1);
      bus.keys = 8'h00; bus.holes = 8'h00; tick(8);

      // saturation: preload 9998 hits, then 4 more, then restart vs hit
      bus.restart = 1'b1; tick(1); bus.restart = 1'b0;
      for (int r = 0; r < 1250; r++) begin
         m = (r == 1249) ? 8'h3F : 8'hFF;
         bus.keys = m; bus.holes = m; tick(7);
         bus.holes = 8'h00; tick(1);
         bus.keys = 8'h00; tick(7);
      end
      chk("preload_score", 32'(bus.score), 32'd9998);
      bus.keys = 8'h0F; bus.holes = 8'h0F; tick(7);
      chk("sat_score", 32'(bus.score), 32'd9999);
      chk("sat_hit",   32'(bus.hit),   32'h0F);
      bus.holes = 8'h00; tick(1);
      bus.keys = 8'h00; tick(7);
      bus.keys = 8'h0F; bus.holes = 8'h0F; tick(6);
      bus.restart = 1'b1; tick(1); bus.restart = 1'b0;
      chk("rs_hit_score",  32'(bus.score),  32'h0);
      chk("rs_hit_misses", 32'(bus.misses), 32'h0);
      chk("rs_hit_hit",    32'(bus.hit),    32'h0F);
      bus.holes = 8'h00; tick(1);
      bus.keys = 8'h00; tick(7);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0)  bus.keys[b]  = ~bus.keys[b];
            if ($urandom_range(0, 11) == 0) bus.holes[b] = ~bus.holes[b];
         end
         if ($urandom_range(0, 99) == 0) bus.en = ~bus.en;
         bus.restart = ($urandom_range(0, 199) == 0);
         tick(1);
      end
      bus.restart = 1'b0; bus.keys = 8'h00; bus.en = 1'b1;
      tick(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
